// File: rtl/execute.sv
// Execute stage: ALU, branch resolution with wrong-path squash, and a
// shift-add MULTU unit writing HI/LO that stalls upstream while busy.
module execute #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_ex_npc,
    input  logic [31:0] id_ex_rdata1,
    input  logic [31:0] id_ex_rdata2,
    input  logic [31:0] id_ex_sign_ext_imm,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  id_ex_rd,
    input  logic [1:0]  id_ex_alu_op,
    input  logic        id_ex_alu_src,
    input  logic        id_ex_reg_dst,
    input  logic        id_ex_branch,
    input  logic        id_ex_mem_read,
    input  logic        id_ex_mem_write,
    input  logic [1:0]  id_ex_ctl_wb,
    output logic        ex_stall,
    output logic        ex_mem_pc_src,
    output logic [31:0] ex_mem_npc,
    output logic [31:0] ex_mem_alu_result,
    output logic        ex_mem_zero,
    output logic [31:0] ex_mem_rdata2,
    output logic [4:0]  ex_mem_write_reg,
    output logic        ex_mem_branch,
    output logic        ex_mem_mem_read,
    output logic        ex_mem_mem_write,
    output logic [1:0]  ex_mem_ctl_wb
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} mul_state_t;

    mul_state_t  state, state_nxt;
    logic [1:0]  squash_cnt;
    logic [CW-1:0] mul_cnt;
    logic [63:0] mul_acc, mul_acc_nxt, mul_mcand;
    logic [31:0] mul_mplier;
    logic [31:0] hi, lo;
    logic        mul_start, mul_done;

    logic [5:0]  funct;
    logic [31:0] op_b, alu_result;
    logic        valid, is_multu, zero, keep;

    assign funct    = id_ex_sign_ext_imm[5:0];
    assign op_b     = id_ex_alu_src ? id_ex_sign_ext_imm : id_ex_rdata2;
    assign valid    = !ex_mem_pc_src && (squash_cnt == 2'd0);
    assign is_multu = (id_ex_alu_op == 2'b10) && (funct == 6'b011001);
    assign zero     = (alu_result == 32'd0);
    // MULTU never writes a register, so it always leaves EX as a bubble.
    assign keep     = valid && !ex_stall && !is_multu;

    always_comb begin
        alu_result = 32'd0;
        case (id_ex_alu_op)
            2'b00: alu_result = id_ex_rdata1 + op_b;
            2'b01: alu_result = id_ex_rdata1 - op_b;
            2'b10: begin
                case (funct)
                    6'b100000: alu_result = id_ex_rdata1 + op_b;
                    6'b100010: alu_result = id_ex_rdata1 - op_b;
                    6'b100100: alu_result = id_ex_rdata1 & op_b;
                    6'b100101: alu_result = id_ex_rdata1 | op_b;
                    6'b101010: alu_result = {31'd0, $signed(id_ex_rdata1) < $signed(op_b)};
                    6'b010000: alu_result = hi;
                    6'b010010: alu_result = lo;
                    default:   alu_result = 32'd0;
                endcase
            end
            default: alu_result = 32'd0;
        endcase
    end

    assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : 64'd0);

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        mul_done  = 1'b0;
        ex_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (valid && is_multu) begin
                    state_nxt = BUSY;
                    mul_start = 1'b1;
                    ex_stall  = 1'b1;
                end
            end
            BUSY: begin
                // Last step releases the stall so the next instruction enters EX
                // on the same edge that HI/LO are written.
                if (mul_cnt == LAST) begin
                    state_nxt = IDLE;
                    mul_done  = 1'b1;
                end else begin
                    ex_stall  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mul_cnt    <= '0;
            mul_acc    <= 64'd0;
            mul_mcand  <= 64'd0;
            mul_mplier <= 32'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            state <= state_nxt;
            if (mul_start) begin
                mul_mcand  <= {32'd0, id_ex_rdata1};
                mul_mplier <= id_ex_rdata2;
                mul_acc    <= 64'd0;
                mul_cnt    <= '0;
            end else if (state == BUSY) begin
                mul_acc    <= mul_acc_nxt;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + CW'(1);
                if (mul_done) begin
                    hi <= mul_acc_nxt[63:32];
                    lo <= mul_acc_nxt[31:0];
                end
            end
        end
    end

    // Kills the ID and IF instructions that follow the EX slot already dropped
    // while ex_mem_pc_src is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_cnt <= 2'd0;
        end else if (ex_mem_pc_src) begin
            squash_cnt <= 2'd2;
        end else if (squash_cnt != 2'd0) begin
            squash_cnt <= squash_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_pc_src     <= 1'b0;
            ex_mem_npc        <= 32'd0;
            ex_mem_alu_result <= 32'd0;
            ex_mem_zero       <= 1'b0;
            ex_mem_rdata2     <= 32'd0;
            ex_mem_write_reg  <= 5'd0;
            ex_mem_branch     <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_ctl_wb     <= 2'd0;
        end else begin
            ex_mem_pc_src     <= keep && id_ex_branch && zero;
            ex_mem_npc        <= id_ex_npc + {id_ex_sign_ext_imm[29:0], 2'b00};
            ex_mem_alu_result <= alu_result;
            ex_mem_zero       <= zero;
            ex_mem_rdata2     <= id_ex_rdata2;
            ex_mem_write_reg  <= id_ex_reg_dst ? id_ex_rd : id_ex_rt;
            ex_mem_branch     <= keep && id_ex_branch;
            ex_mem_mem_read   <= keep && id_ex_mem_read;
            ex_mem_mem_write  <= keep && id_ex_mem_write;
            ex_mem_ctl_wb     <= keep ? id_ex_ctl_wb : 2'd0;
        end
    end
endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: ALU ops, branch squash, MULTU stall
// length and HI/LO results, and reset during a multiply.
module tb_execute;
    logic        clk, rst;
    logic [31:0] id_ex_npc, id_ex_rdata1, id_ex_rdata2, id_ex_sign_ext_imm;
    logic [4:0]  id_ex_rt, id_ex_rd;
    logic [1:0]  id_ex_alu_op, id_ex_ctl_wb;
    logic        id_ex_alu_src, id_ex_reg_dst, id_ex_branch, id_ex_mem_read, id_ex_mem_write;
    logic        ex_stall, ex_mem_pc_src, ex_mem_zero;
    logic [31:0] ex_mem_npc, ex_mem_alu_result, ex_mem_rdata2;
    logic [4:0]  ex_mem_write_reg;
    logic        ex_mem_branch, ex_mem_mem_read, ex_mem_mem_write;
    logic [1:0]  ex_mem_ctl_wb;

    int n_cmp;
    int n_bad;

    execute #(.MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .id_ex_npc(id_ex_npc), .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2),
        .id_ex_sign_ext_imm(id_ex_sign_ext_imm), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src), .id_ex_reg_dst(id_ex_reg_dst),
        .id_ex_branch(id_ex_branch), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_ctl_wb(id_ex_ctl_wb),
        .ex_stall(ex_stall), .ex_mem_pc_src(ex_mem_pc_src), .ex_mem_npc(ex_mem_npc),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_zero(ex_mem_zero),
        .ex_mem_rdata2(ex_mem_rdata2), .ex_mem_write_reg(ex_mem_write_reg),
        .ex_mem_branch(ex_mem_branch), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_ctl_wb(ex_mem_ctl_wb)
    );

    // Posedges at 7, 17, 27, ... so reset release at 15 is clear of an edge.
    initial begin
        clk = 1'b0;
        #7;
        forever begin
            clk = 1'b1;
            #5 clk = 1'b0;
            #5;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        id_ex_npc = 32'd0; id_ex_rdata1 = 32'd0; id_ex_rdata2 = 32'd0;
        id_ex_sign_ext_imm = 32'd0; id_ex_rt = 5'd0; id_ex_rd = 5'd0;
        id_ex_alu_op = 2'b00; id_ex_alu_src = 1'b0; id_ex_reg_dst = 1'b0;
        id_ex_branch = 1'b0; id_ex_mem_read = 1'b0; id_ex_mem_write = 1'b0;
        id_ex_ctl_wb = 2'b00;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        nop();
        id_ex_alu_op = 2'b10; id_ex_reg_dst = 1'b1; id_ex_ctl_wb = 2'b10;
        id_ex_sign_ext_imm = {26'd0, fn};
        id_ex_rdata1 = a; id_ex_rdata2 = b; id_ex_rd = rd; id_ex_rt = 5'd9;
    endtask

    // Wrong-path filler: add that writes a register and stores if it survives.
    task automatic filler();
        nop();
        id_ex_rdata1 = 32'd1; id_ex_rdata2 = 32'd2; id_ex_reg_dst = 1'b1; id_ex_rd = 5'd5;
        id_ex_ctl_wb = 2'b11; id_ex_mem_write = 1'b1;
    endtask

    task automatic beq(input logic [31:0] a, input logic [31:0] b);
        nop();
        id_ex_alu_op = 2'b01; id_ex_branch = 1'b1;
        id_ex_rdata1 = a; id_ex_rdata2 = b; id_ex_npc = 32'h20; id_ex_sign_ext_imm = 32'd4;
    endtask

    function automatic logic [5:0] ctl();
        return {ex_mem_pc_src, ex_mem_branch, ex_mem_mem_read, ex_mem_mem_write, ex_mem_ctl_wb};
    endfunction

    task automatic run_multu(input string tag, input logic [31:0] a, input logic [31:0] b);
        int n;
        rtype(6'b011001, a, b, 5'd0);
        #1;
        n = 0;
        for (int i = 0; i < 100 && ex_stall; i++) begin
            n++;
            tick();
            if (n == 5) chk({tag, "_bubble"}, 64'(ctl()), 64'd0);
        end
        chk({tag, "_stall_cycles"}, 64'(n), 64'd32);
        tick();
        chk({tag, "_retire_bubble"}, 64'(ctl()), 64'd0);
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        rtype(6'b010000, 32'd0, 32'd0, 5'd4);
        tick();
        chk({tag, "_mfhi"}, 64'(ex_mem_alu_result), 64'(exp_hi));
        rtype(6'b010010, 32'd0, 32'd0, 5'd4);
        tick();
        chk({tag, "_mflo"}, 64'(ex_mem_alu_result), 64'(exp_lo));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        nop();
        #15 rst = 1'b0;
        #1;
        chk("rst_ctl", 64'(ctl()), 64'd0);
        chk("rst_data", {ex_mem_alu_result, ex_mem_npc}, 64'd0);
        chk("rst_misc", {ex_mem_rdata2, ex_mem_write_reg, ex_mem_zero, ex_stall}, 64'd0);

        rtype(6'b100000, 32'd5, 32'd7, 5'd3);
        tick();
        chk("add_result", 64'(ex_mem_alu_result), 64'd12);
        chk("add_wreg", 64'(ex_mem_write_reg), 64'd3);
        chk("add_ctl", 64'(ctl()), 64'b000010);

        beq(32'h10, 32'h10);
        tick();
        chk("beq_taken_ctl", 64'(ctl()), 64'b110000);
        chk("beq_taken_npc", 64'(ex_mem_npc), 64'h30);
        for (int i = 0; i < 3; i++) begin
            filler();
            tick();
            chk($sformatf("squash%0d_ctl", i), 64'(ctl()), 64'd0);
            if (i == 0) chk("squash_data", 64'(ex_mem_alu_result), 64'd3);
        end
        filler();
        tick();
        chk("post_squash_ctl", 64'(ctl()), 64'b000111);

        beq(32'h10, 32'h11);
        tick();
        chk("beq_nt_ctl", 64'(ctl()), 64'b010000);
        chk("beq_nt_zero", 64'(ex_mem_zero), 64'd0);
        chk("beq_nt_npc", 64'(ex_mem_npc), 64'h30);
        filler();
        tick();
        chk("beq_nt_no_squash", 64'(ctl()), 64'b000111);

        rtype(6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd6);
        tick();
        chk("slt_neg", 64'(ex_mem_alu_result), 64'd1);
        rtype(6'b101010, 32'd1, 32'hFFFF_FFFF, 5'd6);
        tick();
        chk("slt_pos", 64'(ex_mem_alu_result), 64'd0);
        rtype(6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 5'd7);
        tick();
        chk("and", 64'(ex_mem_alu_result), 64'h0000_F000);
        rtype(6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 5'd7);
        tick();
        chk("or", 64'(ex_mem_alu_result), 64'h0000_FFF0);
        rtype(6'b111111, 32'd9, 32'd4, 5'd7);
        tick();
        chk("unlisted", {ex_mem_alu_result, 31'd0, ex_mem_zero}, {32'd0, 32'd1});
        nop();
        id_ex_rdata1 = 32'h100; id_ex_rdata2 = 32'hABCD; id_ex_alu_src = 1'b1;
        id_ex_sign_ext_imm = 32'hFFFF_FFFC; id_ex_rt = 5'd12; id_ex_mem_write = 1'b1;
        tick();
        chk("imm_add", 64'(ex_mem_alu_result), 64'hFC);
        chk("store_data", {ex_mem_rdata2, 27'd0, ex_mem_write_reg}, {32'hABCD, 32'd12});

        run_multu("mul1", 32'h0001_0000, 32'h0003_0000);
        read_hilo("mul1", 32'h0000_0003, 32'h0000_0000);
        run_multu("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_hilo("mul2", 32'hFFFF_FFFE, 32'h0000_0001);

        // Taken branch resolving while a MULTU sits in ID/EX.
        beq(32'h10, 32'h10);
        tick();
        rtype(6'b011001, 32'd3, 32'd3, 5'd0);
        #1;
        chk("squash_multu_stall", 64'(ex_stall), 64'd0);
        tick();
        chk("squash_multu_ctl", 64'(ctl()), 64'd0);
        chk("squash_multu_stall2", 64'(ex_stall), 64'd0);
        nop();
        tick();
        tick();
        tick();
        read_hilo("after_squash", 32'hFFFF_FFFE, 32'h0000_0001);

        // Reset during BUSY cycle 10.
        rtype(6'b011001, 32'd5, 32'd7, 5'd0);
        #1;
        repeat (11) tick();
        chk("mid_mul_stall", 64'(ex_stall), 64'd1);
        rst = 1'b1;
        nop();
        #1;
        chk("rst_mul_stall", 64'(ex_stall), 64'd0);
        chk("rst_mul_ctl", 64'(ctl()), 64'd0);
        #5 rst = 1'b0;
        filler();
        tick();
        tick();
        chk("rst_mul_idle", 64'(ex_stall), 64'd0);
        read_hilo("rst_mul", 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
